// File: rtl/apb_regbank_slave.sv
// APB4 completer terminating requests in a bank of byte-strobed registers,
// with optional read-only hardware-sourced slots, wait states and pslverr.
package apb_regbank_pkg;
    typedef struct packed {
        logic [31:0] paddr;
        logic [2:0]  pprot;
        logic        psel;
        logic        penable;
        logic        pwrite;
        logic [31:0] pwdata;
        logic [3:0]  pstrb;
    } apb_req_t;

    typedef struct packed {
        logic        pready;
        logic [31:0] prdata;
        logic        pslverr;
    } apb_resp_t;
endpackage

module apb_regbank_slave #(
    parameter int unsigned           NumRegs      = 4,
    parameter int unsigned           DataWidth    = 32,
    parameter int unsigned           AddrWidth    = 32,
    parameter logic [AddrWidth-1:0]  BaseAddr     = '0,
    parameter int unsigned           WaitCycles   = 0,
    parameter logic [NumRegs-1:0]    ReadOnlyMask = '0,
    parameter bit                    PrivOnly     = 1'b0,
    parameter logic [DataWidth-1:0]  RstVal       = '0,
    parameter type                   req_t        = apb_regbank_pkg::apb_req_t,
    parameter type                   resp_t       = apb_regbank_pkg::apb_resp_t
) (
    input  logic                           pclk_i,
    input  logic                           preset_i,
    input  req_t                           apb_req_i,
    output resp_t                          apb_resp_o,
    output logic [NumRegs*DataWidth-1:0]   reg_o,
    output logic [NumRegs-1:0]             reg_wr_o,
    input  logic [NumRegs*DataWidth-1:0]   hw_i
);
    localparam int unsigned NumBytes  = DataWidth / 8;
    localparam int unsigned AlignBits = $clog2(NumBytes);
    localparam int unsigned IdxW      = (NumRegs > 1) ? $clog2(NumRegs) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

    state_e                            state_q, state_d;
    logic [3:0]                        cnt_q, cnt_d;
    logic [NumRegs-1:0][DataWidth-1:0] regs_q, regs_d;
    logic [NumRegs-1:0][DataWidth-1:0] cur;
    logic [AddrWidth-1:0]              off, idx_full;
    logic [IdxW-1:0]                   idx;
    logic                              in_range, misalign, ro, err;
    logic                              unused_bits;

    assign unused_bits = ^apb_req_i.pprot[2:1];

    // Read-only slots expose hw_i; their shadow flops are never written.
    always_comb begin
        for (int unsigned i = 0; i < NumRegs; i++) begin
            cur[i] = ReadOnlyMask[i] ? hw_i[i*DataWidth +: DataWidth] : regs_q[i];
        end
    end
    assign reg_o = cur;

    always_comb begin
        off      = AddrWidth'(apb_req_i.paddr) - BaseAddr;
        idx_full = off >> AlignBits;
        in_range = idx_full < AddrWidth'(NumRegs);
        misalign = (off & AddrWidth'(NumBytes - 1)) != '0;
        idx      = in_range ? idx_full[IdxW-1:0] : '0;
        ro       = in_range && ReadOnlyMask[idx];
        err      = !in_range || misalign || (apb_req_i.pwrite && ro)
                   || (PrivOnly && !apb_req_i.pprot[0]);
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        regs_d   = regs_q;
        reg_wr_o = '0;
        unique case (state_q)
            IDLE: begin
                // A psel with penable already high is accepted as a setup phase.
                if (apb_req_i.psel) begin
                    if (WaitCycles == 0) begin
                        state_d = RESP;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = 4'(WaitCycles);
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (!(apb_req_i.psel && apb_req_i.penable)) begin
                    state_d = IDLE;
                end else if (cnt_q == 4'd1) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
                if (apb_req_i.pwrite && !err) begin
                    reg_wr_o[idx] = 1'b1;
                    for (int unsigned b = 0; b < NumBytes; b++) begin
                        if (apb_req_i.pstrb[b]) begin
                            regs_d[idx][8*b +: 8] = apb_req_i.pwdata[8*b +: 8];
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        apb_resp_o         = '0;
        apb_resp_o.pready  = (state_q == RESP);
        apb_resp_o.pslverr = (state_q == RESP) && err;
        if (state_q == RESP && !apb_req_i.pwrite && !err) begin
            apb_resp_o.prdata = cur[idx];
        end
    end

    always_ff @(posedge pclk_i) begin
        if (preset_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            regs_q  <= {NumRegs{RstVal}};
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            regs_q  <= regs_d;
        end
    end
endmodule

// File: tb/tb_apb_regbank_slave.sv
// Self-checking bench: dut_a (no wait states, reg 2 read-only) and
// dut_b (three wait states, privileged-only), checked through a scoreboard.
module tb_apb_regbank_slave;
    import apb_regbank_pkg::*;

    localparam logic [31:0] BASE = 32'h0000_1000;
    localparam logic [31:0] RST  = 32'hA5A5_0000;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic [3:0]  wr;
        int unsigned lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_a, rst_b;
    apb_req_t    req_a, req_b;
    apb_resp_t   resp_a, resp_b;
    logic [127:0] reg_a, reg_b, hw_a, hw_b;
    logic [3:0]  wr_a, wr_b;

    exp_t        sb_q[$];
    logic [31:0] mdl_a[4];
    logic [31:0] mdl_b[4];
    int unsigned checks = 0;
    int unsigned errors = 0;

    always #5 clk = ~clk;

    apb_regbank_slave #(
        .NumRegs(4), .DataWidth(32), .AddrWidth(32), .BaseAddr(BASE),
        .WaitCycles(0), .ReadOnlyMask(4'b0100), .PrivOnly(1'b0), .RstVal(RST)
    ) dut_a (
        .pclk_i(clk), .preset_i(rst_a), .apb_req_i(req_a), .apb_resp_o(resp_a),
        .reg_o(reg_a), .reg_wr_o(wr_a), .hw_i(hw_a)
    );

    apb_regbank_slave #(
        .NumRegs(4), .DataWidth(32), .AddrWidth(32), .BaseAddr(BASE),
        .WaitCycles(3), .ReadOnlyMask(4'b0000), .PrivOnly(1'b1), .RstVal(RST)
    ) dut_b (
        .pclk_i(clk), .preset_i(rst_b), .apb_req_i(req_b), .apb_resp_o(resp_b),
        .reg_o(reg_b), .reg_wr_o(wr_b), .hw_i(hw_b)
    );

    task automatic drive(input bit sel_b, input apb_req_t r);
        if (sel_b) req_b = r;
        else       req_a = r;
    endtask

    task automatic idle_bus(input bit sel_b, input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            @(posedge clk); #1;
            drive(sel_b, '0);
        end
    endtask

    // One APB transfer; drop_at>0 removes psel in that access cycle.
    task automatic apb_xfer(input bit sel_b, input bit wr, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [3:0] strb,
                            input logic [2:0] prot, input int unsigned drop_at,
                            input bit viol);
        apb_req_t    r;
        apb_resp_t   rs;
        logic [3:0]  wv;
        exp_t        e;
        logic [31:0] offs, idx;
        bit          inr, ro, done;
        offs = addr - BASE;
        idx  = offs >> 2;
        inr  = offs < 32'd16;
        ro   = !sel_b && inr && idx == 32'd2;
        e.err   = !inr || offs[1:0] != 2'b00 || (wr && ro) || (sel_b && !prot[0]);
        e.rdata = '0;
        if (!wr && !e.err) begin
            if (ro)         e.rdata = hw_a[64 +: 32];
            else if (sel_b) e.rdata = mdl_b[idx[1:0]];
            else            e.rdata = mdl_a[idx[1:0]];
        end
        e.wr  = (wr && !e.err) ? (4'b0001 << idx[1:0]) : 4'b0000;
        e.lat = sel_b ? 4 : 1;

        r = '0;
        r.paddr = addr; r.pprot = prot; r.psel = 1'b1; r.penable = viol;
        r.pwrite = wr; r.pwdata = wdata; r.pstrb = strb;
        @(posedge clk); #1;
        drive(sel_b, r);
        if (drop_at == 0) sb_q.push_back(e);
        @(negedge clk);
        rs = sel_b ? resp_b : resp_a;
        checks++;
        if (rs.pready !== 1'b0) begin
            errors++;
            $display("FAIL setup_pready: got %b expected 0", rs.pready);
        end
        r.penable = 1'b1;
        done = 1'b0;
        for (int unsigned k = 1; k <= 8 && !done; k++) begin
            @(posedge clk); #1;
            if (drop_at != 0 && k == drop_at) begin
                r.psel = 1'b0; r.penable = 1'b0;
            end
            drive(sel_b, r);
            @(negedge clk);
            rs = sel_b ? resp_b : resp_a;
            wv = sel_b ? wr_b : wr_a;
            if (drop_at != 0 && k == drop_at) begin
                checks++;
                if (rs.pready !== 1'b0 || wv !== 4'b0000) begin
                    errors++;
                    $display("FAIL drop: got pready=%b wr=%b expected 0/0000", rs.pready, wv);
                end
                done = 1'b1;
            end else if (rs.pready === 1'b1) begin
                done = 1'b1;
                if (sb_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_pready: got 1 expected 0");
                end else begin
                    e = sb_q.pop_front();
                    checks += 4;
                    if (k !== e.lat) begin
                        errors++;
                        $display("FAIL latency @%h: got %0d expected %0d", addr, k, e.lat);
                    end
                    if (rs.pslverr !== e.err) begin
                        errors++;
                        $display("FAIL pslverr @%h: got %b expected %b", addr, rs.pslverr, e.err);
                    end
                    if (rs.prdata !== e.rdata) begin
                        errors++;
                        $display("FAIL prdata @%h: got %h expected %h", addr, rs.prdata, e.rdata);
                    end
                    if (wv !== e.wr) begin
                        errors++;
                        $display("FAIL reg_wr @%h: got %b expected %b", addr, wv, e.wr);
                    end
                    if (e.wr != 4'b0000) begin
                        for (int unsigned b = 0; b < 4; b++) begin
                            if (strb[b]) begin
                                if (sel_b) mdl_b[idx[1:0]][8*b +: 8] = wdata[8*b +: 8];
                                else       mdl_a[idx[1:0]][8*b +: 8] = wdata[8*b +: 8];
                            end
                        end
                    end
                end
            end else begin
                checks++;
                if (rs.pslverr !== 1'b0 || rs.prdata !== 32'h0 || wv !== 4'b0000) begin
                    errors++;
                    $display("FAIL quiet_outputs: got err=%b rdata=%h wr=%b expected 0", rs.pslverr, rs.prdata, wv);
                end
            end
        end
        if (!done) begin
            checks++; errors++;
            $display("FAIL timeout @%h: got no pready expected pready", addr);
            if (sb_q.size() > 0) void'(sb_q.pop_front());
        end
    endtask

    task automatic test_regs(input bit sel_b, input string tag);
        logic [31:0] got, want;
        for (int unsigned i = 0; i < 4; i++) begin
            got  = sel_b ? reg_b[32*i +: 32] : reg_a[32*i +: 32];
            want = sel_b ? mdl_b[i] : ((i == 2) ? hw_a[64 +: 32] : mdl_a[i]);
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL %s reg%0d: got %h expected %h", tag, i, got, want);
            end
        end
    endtask

    task automatic test_reset;
        rst_a = 1'b1; rst_b = 1'b1;
        req_a = '0; req_b = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            mdl_a[i] = RST; mdl_b[i] = RST;
        end
        repeat (2) @(posedge clk);
        #1;
        rst_a = 1'b0; rst_b = 1'b0;
        @(negedge clk);
        checks += 2;
        if (resp_a.pready !== 1'b0 || resp_a.pslverr !== 1'b0 || resp_a.prdata !== 32'h0 || wr_a !== 4'b0) begin
            errors++;
            $display("FAIL reset_a_outputs: got %b/%b/%h/%b expected 0", resp_a.pready, resp_a.pslverr, resp_a.prdata, wr_a);
        end
        if (resp_b.pready !== 1'b0 || wr_b !== 4'b0) begin
            errors++;
            $display("FAIL reset_b_outputs: got %b/%b expected 0", resp_b.pready, wr_b);
        end
        test_regs(1'b0, "reset_a");
        test_regs(1'b1, "reset_b");
    endtask

    task automatic test_write_read;
        apb_xfer(1'b0, 1'b1, BASE + 4, 32'hDEAD_BEEF, 4'hF, 3'b000, 0, 1'b0);
        apb_xfer(1'b0, 1'b0, BASE + 4, 32'h0, 4'h0, 3'b000, 0, 1'b0);
        idle_bus(1'b0, 1);
        test_regs(1'b0, "write_read");
    endtask

    task automatic test_strobes;
        apb_xfer(1'b0, 1'b1, BASE, 32'h0, 4'hF, 3'b000, 0, 1'b0);
        apb_xfer(1'b0, 1'b1, BASE, 32'h1122_3344, 4'b0101, 3'b000, 0, 1'b0);
        apb_xfer(1'b0, 1'b0, BASE, 32'h0, 4'h0, 3'b000, 0, 1'b0);
        apb_xfer(1'b0, 1'b1, BASE + 12, 32'hFFFF_FFFF, 4'b0000, 3'b000, 0, 1'b0);
        idle_bus(1'b0, 1);
        checks++;
        if (reg_a[31:0] !== 32'h0022_0044) begin
            errors++;
            $display("FAIL strobe_value: got %h expected 00220044", reg_a[31:0]);
        end
        test_regs(1'b0, "strobes");
    endtask

    task automatic test_errors;
        apb_xfer(1'b0, 1'b1, BASE + 16, 32'h1234_5678, 4'hF, 3'b000, 0, 1'b0);
        apb_xfer(1'b0, 1'b1, BASE + 2, 32'h1234_5678, 4'hF, 3'b000, 0, 1'b0);
        apb_xfer(1'b0, 1'b1, BASE + 8, 32'h1234_5678, 4'hF, 3'b000, 0, 1'b0);
        apb_xfer(1'b0, 1'b0, BASE - 4, 32'h0, 4'h0, 3'b000, 0, 1'b0);
        apb_xfer(1'b0, 1'b0, BASE + 8, 32'h0, 4'h0, 3'b000, 0, 1'b0);
        idle_bus(1'b0, 1);
        test_regs(1'b0, "errors");
    endtask

    task automatic test_wait_states;
        apb_xfer(1'b1, 1'b1, BASE + 12, 32'hCAFE_F00D, 4'hF, 3'b001, 0, 1'b0);
        idle_bus(1'b1, 1);
        apb_xfer(1'b1, 1'b1, BASE + 12, 32'h0BAD_0BAD, 4'hF, 3'b001, 2, 1'b0);
        idle_bus(1'b1, 2);
        apb_xfer(1'b1, 1'b0, BASE + 12, 32'h0, 4'h0, 3'b001, 0, 1'b0);
        idle_bus(1'b1, 1);
        test_regs(1'b1, "wait_states");
    endtask

    task automatic test_priv;
        apb_xfer(1'b1, 1'b0, BASE, 32'h0, 4'h0, 3'b000, 0, 1'b0);
        apb_xfer(1'b1, 1'b1, BASE, 32'h5555_5555, 4'hF, 3'b010, 0, 1'b0);
        idle_bus(1'b1, 1);
        test_regs(1'b1, "priv");
    endtask

    task automatic test_back_to_back;
        apb_xfer(1'b0, 1'b1, BASE + 12, 32'h0102_0304, 4'hF, 3'b000, 0, 1'b0);
        apb_xfer(1'b0, 1'b0, BASE + 12, 32'h0, 4'h0, 3'b000, 0, 1'b0);
        apb_xfer(1'b0, 1'b0, BASE + 4, 32'h0, 4'h0, 3'b000, 0, 1'b1);
        apb_xfer(1'b0, 1'b1, BASE + 4, 32'h7777_8888, 4'b1100, 3'b000, 0, 1'b1);
        idle_bus(1'b0, 1);
        test_regs(1'b0, "back_to_back");
    endtask

    task automatic test_reset_abort;
        apb_req_t r;
        r = '0;
        r.paddr = BASE + 4; r.pprot = 3'b001; r.psel = 1'b1;
        r.pwrite = 1'b1; r.pwdata = 32'h9999_AAAA; r.pstrb = 4'hF;
        @(posedge clk); #1; req_b = r;
        @(posedge clk); #1; r.penable = 1'b1; req_b = r;
        @(posedge clk); #1; rst_b = 1'b1;
        @(negedge clk);
        @(posedge clk); #1; rst_b = 1'b0; req_b = '0;
        @(negedge clk);
        checks += 2;
        if (resp_b.pready !== 1'b0 || wr_b !== 4'b0000) begin
            errors++;
            $display("FAIL abort_outputs: got pready=%b wr=%b expected 0/0000", resp_b.pready, wr_b);
        end
        if (reg_b[63:32] !== RST) begin
            errors++;
            $display("FAIL abort_reg: got %h expected %h", reg_b[63:32], RST);
        end
        for (int unsigned i = 0; i < 4; i++) mdl_b[i] = RST;
        apb_xfer(1'b1, 1'b0, BASE + 4, 32'h0, 4'h0, 3'b001, 0, 1'b0);
        idle_bus(1'b1, 1);
        test_regs(1'b1, "reset_abort");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        hw_a = '0;
        hw_a[31:0]   = 32'hBAD0_BAD0;
        hw_a[64 +: 32] = 32'h0000_CAFE;
        hw_b = {4{32'h1357_9BDF}};
        test_reset();
        test_write_read();
        test_strobes();
        test_errors();
        test_wait_states();
        test_priv();
        test_back_to_back();
        test_reset_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
